rf_wb_scheduler: RTL
====================

# rf_wb_scheduler

Write-back scheduler and scoreboard for the integer register file. It shares the single register-file write port between two write-back requesters, the ALU and the LSU, using round-robin arbitration. It also tracks which destination registers have pending writes, so the issue stage can stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file's write port (wr_rd, wr_data, plus the write enable this block drives).

## Interface
- REG_NUM, 32, number of architectural registers; x0 is hard-wired zero and never tracked
- Widths INSTR_REG_BITS and WD_SIZE come from PARAMS_pkg
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- iss_valid  in  1  issue stage presents an instruction
- iss_rs1, iss_rs2, iss_rd  in  INSTR_REG_BITS  source and destination indices of that instruction
- iss_stall  out  1  combinational hazard stall to issue stage
- alu_valid  in  1  ALU result pending
- alu_rd  in  INSTR_REG_BITS  ALU destination index
- alu_data  in  WD_SIZE  ALU result value
- alu_ready  out  1  combinational grant to the ALU
- lsu_valid  in  1  LSU result pending
- lsu_rd  in  INSTR_REG_BITS  LSU destination index
- lsu_data  in  WD_SIZE  LSU result value
- lsu_ready  out  1  combinational grant to the LSU
- wr_en, wr_rd, wr_data  out  1 / INSTR_REG_BITS / WD_SIZE  registered register-file write port
- busy  out  REG_NUM  scoreboard, one bit per register; bit 0 constantly 0
- wb_err  out  1  sticky: a write-back targeted a non-busy register

## Operation
- **Hazard check:**
  - iss_stall = iss_valid && (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]).
  - Index 0 never hits, since busy[0] is always 0.
- **Issue accept:**
  - An instruction is accepted when iss_valid && !iss_stall.
  - On accept, busy[iss_rd] is set at the next edge, unless iss_rd == 0.
- **Arbitration:**
  - A handshake completes when valid && ready.
  - If only one source is valid, that source gets ready.
  - If both are valid, the source not granted last gets ready.
  - A last_grant register updates on every completed handshake.
  - Ready never asserts without the matching valid.
  - A requester holds valid, rd and data stable until ready.
- **Write port:**
  - The granted rd/data are registered onto wr_rd/wr_data.
  - wr_en = 1 only if the granted rd != 0.
  - An x0 write-back is consumed (ready given) but produces wr_en = 0.
  - With no grant: wr_en = 0, and wr_rd/wr_data hold their previous values.
- **Scoreboard clear:**
  - busy[wr_rd] clears at the edge ending the cycle in which wr_en = 1, i.e. when the register file commits.
- **Set/clear collision:**
  - If a set (issue) and a clear (commit) of the same index happen at the same edge, the set wins: the new writer owns the register.
- **Error flag:**
  - wb_err is set at the grant edge if the granted rd != 0 and busy[rd] = 0.
  - Once set, it clears only on reset.
- **Reset:**
  - Asserting reset_n low at any time immediately forces busy = 0, wr_en = 0, wr_rd = 0, wr_data = 0, wb_err = 0, and last_grant = LSU, so the ALU wins the first tie.
  - An in-flight grant is lost.

## Timing
- Grant in cycle N → wr_en/wr_rd/wr_data valid in cycle N+1 → register file writes at the end of N+1.
- busy[rd] falls at the end of N+1, so a dependent instruction's iss_stall drops in N+2. The updated register value is readable combinationally in that same cycle.
- Issue accepted in cycle M → busy[rd] = 1 from M+1. A write-back for that rd is legal from M+1.
- Sustained throughput is one write-back per cycle.
- **Fairness:** with both sources continuously valid, grants alternate ALU, LSU, ALU, …
- A single valid source is granted every cycle; there is no bubble.
- **Same rd from both sources in one cycle:** only the granted source writes. The other waits its turn and clears busy again (wb_err may set; software/pipeline must avoid this).
- Ready, iss_stall and the hazard compare are combinational from registered state plus current inputs. There is no combinational valid→valid loop.

## Structure
- **PARAMS_pkg additions:**
  - typedef enum logic {WB_ALU, WB_LSU} wb_src_e.
  - The REG_NUM default constant.
- **Sub-module rr_arb2:**
  - Two-requester round-robin arbiter.
  - Ports: clk, reset_n, req[1:0], gnt[1:0].
  - Holds last_grant internally.
- **Top level:**
  - busy vector.
  - Write-port registers.
  - wb_err flag.
  - Hazard compare.

## Test plan
- Reset, then iss_valid with rd=5, rs1=rs2=0 → iss_stall=0; busy[5]=1 next cycle. ALU write-back rd=5, data=0xDEADBEEF → alu_ready same cycle; wr_en=1, wr_rd=5, wr_data=0xDEADBEEF next cycle; busy[5]=0 the cycle after.
- busy[7]=1, iss_valid with rs1=7 → iss_stall=1 until the cycle after wr_en with wr_rd=7. A second issue with rd=7 (WAW) also stalls.
- ALU and LSU both valid for 4 cycles (rd=1..4, all busy) → grant order ALU, LSU, ALU, LSU; wr_en=1 each cycle; wb_err=0.
- LSU write-back with rd=0 → lsu_ready=1, wr_en=0 next cycle, busy unchanged, wb_err=0.
- Issue rd=9 in the same cycle as the commit of wr_rd=9 → busy[9] remains 1.
- ALU write-back rd=12 with busy[12]=0 → wb_err=1 and stays set. reset_n pulsed low mid-stream → all outputs, busy and wb_err go to 0 immediately.

Source files
------------

// File: rtl/PARAMS_pkg.sv
// Shared widths and types for the integer register-file write-back path.
package PARAMS_pkg;

  localparam int unsigned INSTR_REG_BITS = 5;
  localparam int unsigned WD_SIZE        = 32;
  localparam int unsigned REG_NUM_DEF    = 32;

  // Encoding doubles as the requester's bit position in req/gnt vectors.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2
  import PARAMS_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e last_grant_q, last_grant_d;

  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant_q == WB_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    // A grant is only ever issued alongside its request, so a grant is a handshake.
    if (gnt[0]) begin
      last_grant_d = WB_ALU;
    end else if (gnt[1]) begin
      last_grant_d = WB_LSU;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= WB_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-back scheduler: arbitrates ALU/LSU onto the single write port and
// keeps a per-register pending-write scoreboard for issue-stage hazard stalls.
module rf_wb_scheduler
  import PARAMS_pkg::*;
#(
  parameter int unsigned REG_NUM = REG_NUM_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  // Issue stage
  input  logic                      iss_valid,
  input  logic [INSTR_REG_BITS-1:0] iss_rs1,
  input  logic [INSTR_REG_BITS-1:0] iss_rs2,
  input  logic [INSTR_REG_BITS-1:0] iss_rd,
  output logic                      iss_stall,
  // ALU write-back
  input  logic                      alu_valid,
  input  logic [INSTR_REG_BITS-1:0] alu_rd,
  input  logic [WD_SIZE-1:0]        alu_data,
  output logic                      alu_ready,
  // LSU write-back
  input  logic                      lsu_valid,
  input  logic [INSTR_REG_BITS-1:0] lsu_rd,
  input  logic [WD_SIZE-1:0]        lsu_data,
  output logic                      lsu_ready,
  // Register-file write port
  output logic                      wr_en,
  output logic [INSTR_REG_BITS-1:0] wr_rd,
  output logic [WD_SIZE-1:0]        wr_data,
  // Status
  output logic [REG_NUM-1:0]        busy,
  output logic                      wb_err
);

  logic [1:0] req, gnt;

  logic [REG_NUM-1:0]        busy_q, busy_d;
  logic                      wr_en_q, wr_en_d;
  logic [INSTR_REG_BITS-1:0] wr_rd_q, wr_rd_d;
  logic [WD_SIZE-1:0]        wr_data_q, wr_data_d;
  logic                      wb_err_q, wb_err_d;

  logic                      grant;
  logic [INSTR_REG_BITS-1:0] grant_rd;
  logic [WD_SIZE-1:0]        grant_data;
  logic                      iss_hit;
  logic                      iss_accept;

  assign req = {lsu_valid, alu_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  assign alu_ready = gnt[0];
  assign lsu_ready = gnt[1];

  always_comb begin
    grant      = |gnt;
    grant_rd   = alu_rd;
    grant_data = alu_data;
    if (gnt[1]) begin
      grant_rd   = lsu_rd;
      grant_data = lsu_data;
    end
  end

  // busy[0] is held at zero, so x0 indices never produce a hazard.
  always_comb begin
    iss_hit    = busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd];
    iss_stall  = iss_valid & iss_hit;
    iss_accept = iss_valid & ~iss_hit;
  end

  always_comb begin
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    wb_err_d  = wb_err_q;

    // Clear on commit first so a same-edge issue to the same index overrides it.
    if (wr_en_q) begin
      busy_d[wr_rd_q] = 1'b0;
    end
    if (iss_accept && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (grant) begin
      wr_en_d   = (grant_rd != '0);
      wr_rd_d   = grant_rd;
      wr_data_d = grant_data;
      if ((grant_rd != '0) && !busy_q[grant_rd]) begin
        wb_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_rd   = wr_rd_q;
  assign wr_data = wr_data_q;
  assign wb_err  = wb_err_q;

endmodule
